// File: rtl/forwarding_hazard_ctrl_pkg.sv
// Shared definitions for the operand-fetch forwarding/hazard controller:
// forwarding select codes and the per-stage pipeline record.
package forwarding_hazard_ctrl_pkg;

  // Register fields are stored at this width; the top zero-extends narrower addresses.
  localparam int RW_W = 8;

  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_EX = 2'b01;
  localparam logic [1:0] SEL_DM = 2'b10;
  localparam logic [1:0] SEL_WB = 2'b11;

  typedef struct packed {
    logic            valid;
    logic [RW_W-1:0] rw;
    logic            reg_write;
    logic            is_load;
  } stage_rec_t;

  // r0 is hardwired, so it never produces a forwarding hit.
  function automatic logic stage_hit(input stage_rec_t rec, input logic [RW_W-1:0] addr);
    return rec.valid && rec.reg_write && (rec.rw == addr) && (addr != '0);
  endfunction

endpackage

// File: rtl/forwarding_hazard_ctrl_operand_forward_select.sv
// Picks the newest producer of one source operand among EX, DM and WB,
// and flags when that newest producer is a load still sitting in EX.
module operand_forward_select
  import forwarding_hazard_ctrl_pkg::*;
(
  input  logic [RW_W-1:0] addr,
  input  stage_rec_t      ex_rec,
  input  stage_rec_t      dm_rec,
  input  stage_rec_t      wb_rec,
  output logic [1:0]      sel,
  output logic            ex_load_hit
);

  logic ex_hit;
  logic dm_hit;
  logic wb_hit;
  logic unused_load_bits;

  assign ex_hit = stage_hit(ex_rec, addr);
  assign dm_hit = stage_hit(dm_rec, addr);
  assign wb_hit = stage_hit(wb_rec, addr);

  assign ex_load_hit      = ex_hit && ex_rec.is_load;
  assign unused_load_bits = dm_rec.is_load ^ wb_rec.is_load;

  // Younger stages win: EX holds the most recent write to the register.
  always_comb begin
    sel = SEL_RF;
    if (ex_hit) begin
      sel = SEL_EX;
    end else if (dm_hit) begin
      sel = SEL_DM;
    end else if (wb_hit) begin
      sel = SEL_WB;
    end
  end

endmodule

// File: rtl/forwarding_hazard_ctrl.sv
// Operand-fetch sequencing for the 5-stage pipeline: tracks in-flight writers,
// drives the forwarding selects, detects load-use stalls and drives write-back.
module forwarding_hazard_ctrl
  import forwarding_hazard_ctrl_pkg::*;
#(
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [AW-1:0] id_RA,
  input  logic [AW-1:0] id_RB,
  input  logic [AW-1:0] id_RW,
  input  logic          id_uses_imm,
  input  logic          id_reg_write,
  input  logic          id_is_load,
  input  logic          flush,
  output logic [1:0]    mux_sel_A,
  output logic [1:0]    mux_sel_B,
  output logic          imm_sel,
  output logic          stall,
  output logic [AW-1:0] wb_RW,
  output logic          wb_wr_en,
  output logic [CW-1:0] stall_count
);

  stage_rec_t      ex_reg;
  stage_rec_t      dm_reg;
  stage_rec_t      wb_reg;
  stage_rec_t      id_rec;
  logic [CW-1:0]   stall_count_reg;
  logic [RW_W-1:0] src_addr [2];
  logic [1:0]      src_sel [2];
  logic            src_load_hit [2];
  logic            active;

  always_comb begin
    id_rec              = '0;
    id_rec.valid        = id_valid;
    id_rec.rw[AW-1:0]   = id_RW;
    id_rec.reg_write    = id_reg_write;
    id_rec.is_load      = id_is_load;
    src_addr[0]         = '0;
    src_addr[0][AW-1:0] = id_RA;
    src_addr[1]         = '0;
    src_addr[1][AW-1:0] = id_RB;
  end

  // Index 0 resolves RA, index 1 resolves RB.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      operand_forward_select u_sel (
        .addr        (src_addr[gi]),
        .ex_rec      (ex_reg),
        .dm_rec      (dm_reg),
        .wb_rec      (wb_reg),
        .sel         (src_sel[gi]),
        .ex_load_hit (src_load_hit[gi])
      );
    end
  endgenerate

  // Reset gates the decode-side outputs so a held reset never shows a stall.
  assign active    = rst_n && id_valid;
  assign mux_sel_A = active ? src_sel[0] : SEL_RF;
  assign mux_sel_B = active ? src_sel[1] : SEL_RF;
  assign imm_sel   = active && id_uses_imm;
  // An immediate B operand only needs RB for store data, which can wait a stage.
  assign stall     = active && !flush &&
                     (src_load_hit[0] || (src_load_hit[1] && !id_uses_imm));

  assign wb_RW       = wb_reg.rw[AW-1:0];
  assign wb_wr_en    = wb_reg.valid && wb_reg.reg_write && (wb_reg.rw != '0);
  assign stall_count = stall_count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_reg          <= '0;
      dm_reg          <= '0;
      wb_reg          <= '0;
      stall_count_reg <= '0;
    end else begin
      wb_reg <= dm_reg;
      dm_reg <= ex_reg;
      ex_reg <= (id_valid && !stall && !flush) ? id_rec : '0;
      if (stall && (stall_count_reg != '1)) begin
        stall_count_reg <= stall_count_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_forwarding_hazard_ctrl.sv
// Scenario bench for forwarding_hazard_ctrl: each step drives one decode slot,
// queues its expected outputs and compares them mid-cycle.
module tb_forwarding_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_RA;
  logic [4:0] id_RB;
  logic [4:0] id_RW;
  logic       id_uses_imm;
  logic       id_reg_write;
  logic       id_is_load;
  logic       flush;
  logic [1:0] mux_sel_A;
  logic [1:0] mux_sel_B;
  logic       imm_sel;
  logic       stall;
  logic [4:0] wb_RW;
  logic       wb_wr_en;
  logic [3:0] stall_count;

  int errors = 0;
  int checks = 0;

  localparam logic [15:0] M_A   = 16'hC000;
  localparam logic [15:0] M_B   = 16'h3000;
  localparam logic [15:0] M_IMM = 16'h0800;
  localparam logic [15:0] M_ST  = 16'h0400;
  localparam logic [15:0] M_WE  = 16'h0200;
  localparam logic [15:0] M_WRW = 16'h01F0;
  localparam logic [15:0] M_CNT = 16'h000F;
  localparam logic [15:0] M_ALL = 16'hFFFF;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        v;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rw;
    logic        ui;
    logic        wr;
    logic        ld;
    logic        fl;
    logic [15:0] exp;
    logic [15:0] mask;
  } step_t;

  step_t sb[$];

  forwarding_hazard_ctrl #(.AW(5), .CW(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_RA        (id_RA),
    .id_RB        (id_RB),
    .id_RW        (id_RW),
    .id_uses_imm  (id_uses_imm),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .flush        (flush),
    .mux_sel_A    (mux_sel_A),
    .mux_sel_B    (mux_sel_B),
    .imm_sel      (imm_sel),
    .stall        (stall),
    .wb_RW        (wb_RW),
    .wb_wr_en     (wb_wr_en),
    .stall_count  (stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] ev(int a, int b, int imm, int st, int we, int wrw, int cnt);
    return {a[1:0], b[1:0], imm[0], st[0], we[0], wrw[4:0], cnt[3:0]};
  endfunction

  function automatic logic [15:0] obs();
    return {mux_sel_A, mux_sel_B, imm_sel, stall, wb_wr_en, wb_RW, stall_count};
  endfunction

  function automatic step_t ins(string n, int ra, int rb, int rw, int ui, int wr, int ld,
                                int fl, logic [15:0] e, logic [15:0] m);
    step_t s;
    s.name = n;   s.rst_n = 1'b1; s.v = 1'b1;
    s.ra = ra[4:0]; s.rb = rb[4:0]; s.rw = rw[4:0];
    s.ui = ui[0]; s.wr = wr[0]; s.ld = ld[0]; s.fl = fl[0];
    s.exp = e;    s.mask = m;
    return s;
  endfunction

  function automatic step_t bub(string n, logic [15:0] e, logic [15:0] m);
    step_t s;
    s = ins(n, 0, 0, 0, 0, 0, 0, 0, e, m);
    s.v = 1'b0;
    return s;
  endfunction

  // Stimulus side: apply one decode slot at the falling edge and queue its expectation.
  task automatic drive(input step_t s);
    @(negedge clk);
    rst_n = s.rst_n; id_valid = s.v; id_RA = s.ra; id_RB = s.rb; id_RW = s.rw;
    id_uses_imm = s.ui; id_reg_write = s.wr; id_is_load = s.ld; flush = s.fl;
    sb.push_back(s);
  endtask

  task automatic test_reset();
    step_t t[$];
    step_t e;
    logic [15:0] got;
    for (int i = 0; i < 2; i++) begin
      t.push_back(ins("rst_hold", 5, 5, 5, 1, 1, 1, 0, 16'h0000, M_ALL));
      t[$].rst_n = 1'b0;
    end
    for (int i = 0; i < 3; i++) t.push_back(bub("rst_release", 16'h0000, M_ALL));
    foreach (t[i]) begin
      drive(t[i]);
      #2;
      e = sb.pop_front();
      got = obs();
      if (e.mask != 16'h0000) begin
        checks++;
        $display("step %s obs=%h", e.name, got);
        if ((got & e.mask) !== (e.exp & e.mask)) begin
          errors++;
          $display("FAIL %s: got=%h expected=%h mask=%h", e.name, got, e.exp, e.mask);
        end
      end
    end
  endtask

  task automatic test_alu_chain();
    step_t t[$];
    step_t e;
    logic [15:0] got;
    logic [1:0] want [4];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b11; want[3] = 2'b00;
    for (int g = 0; g < 4; g++) begin
      t.push_back(ins("alu_wr5", 1, 2, 5, 0, 1, 0, 0, 16'h0, 16'h0));
      for (int k = 0; k < g; k++) t.push_back(ins("alu_mid", 1, 2, 10, 0, 1, 0, 0, 16'h0, 16'h0));
      t.push_back(ins($sformatf("alu_gap%0d", g), 5, 3, 11, 0, 0, 0, 0,
                      ev(int'(want[g]), 0, 0, 0, 0, 0, 0), M_A | M_B | M_ST));
      for (int k = 0; k < 3; k++) t.push_back(bub("drain", 16'h0, 16'h0));
    end
    foreach (t[i]) begin
      drive(t[i]);
      #2;
      e = sb.pop_front();
      got = obs();
      if (e.mask != 16'h0000) begin
        checks++;
        $display("step %s obs=%h", e.name, got);
        if ((got & e.mask) !== (e.exp & e.mask)) begin
          errors++;
          $display("FAIL %s: got=%h expected=%h mask=%h", e.name, got, e.exp, e.mask);
        end
      end
    end
  endtask

  task automatic test_priority();
    step_t t[$];
    step_t e;
    logic [15:0] got;
    t.push_back(ins("pri_w7a", 1, 2, 7, 0, 1, 0, 0, 16'h0, 16'h0));
    t.push_back(ins("pri_w7b", 1, 2, 7, 0, 1, 0, 0, 16'h0, 16'h0));
    t.push_back(ins("pri_rb7_ex", 3, 7, 11, 0, 0, 0, 0, ev(0, 1, 0, 0, 0, 0, 0), M_A | M_B | M_IMM | M_ST));
    t.push_back(ins("pri_rb7_dm", 3, 7, 11, 0, 0, 0, 0, ev(0, 2, 0, 0, 0, 0, 0), M_A | M_B | M_ST));
    t.push_back(ins("pri_w0", 1, 2, 0, 0, 1, 0, 0, 16'h0, 16'h0));
    t.push_back(ins("pri_r0", 0, 0, 12, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0), M_A | M_B));
    t.push_back(ins("pri_w8", 1, 2, 8, 0, 1, 0, 0, 16'h0, 16'h0));
    t.push_back(ins("pri_store", 1, 8, 0, 1, 0, 0, 0, ev(0, 1, 1, 0, 0, 0, 0), M_A | M_B | M_IMM | M_ST));
    for (int k = 0; k < 3; k++) t.push_back(bub("drain", 16'h0, 16'h0));
    foreach (t[i]) begin
      drive(t[i]);
      #2;
      e = sb.pop_front();
      got = obs();
      if (e.mask != 16'h0000) begin
        checks++;
        $display("step %s obs=%h", e.name, got);
        if ((got & e.mask) !== (e.exp & e.mask)) begin
          errors++;
          $display("FAIL %s: got=%h expected=%h mask=%h", e.name, got, e.exp, e.mask);
        end
      end
    end
  endtask

  task automatic test_writeback();
    step_t t[$];
    step_t e;
    logic [15:0] got;
    t.push_back(ins("wb_w9", 1, 2, 9, 0, 1, 0, 0, 16'h0, 16'h0));
    t.push_back(bub("wb_n1", ev(0, 0, 0, 0, 0, 0, 0), M_WE));
    t.push_back(bub("wb_n2", ev(0, 0, 0, 0, 0, 0, 0), M_WE));
    t.push_back(bub("wb_n3", ev(0, 0, 0, 0, 1, 9, 0), M_WE | M_WRW));
    t.push_back(bub("wb_n4", ev(0, 0, 0, 0, 0, 0, 0), M_WE));
    t.push_back(ins("wb_w0", 1, 2, 0, 0, 1, 0, 0, 16'h0, 16'h0));
    t.push_back(bub("drain", 16'h0, 16'h0));
    t.push_back(bub("drain", 16'h0, 16'h0));
    t.push_back(bub("wb_r0_blocked", ev(0, 0, 0, 0, 0, 0, 0), M_WE));
    for (int k = 0; k < 3; k++) t.push_back(bub("drain", 16'h0, 16'h0));
    foreach (t[i]) begin
      drive(t[i]);
      #2;
      e = sb.pop_front();
      got = obs();
      if (e.mask != 16'h0000) begin
        checks++;
        $display("step %s obs=%h", e.name, got);
        if ((got & e.mask) !== (e.exp & e.mask)) begin
          errors++;
          $display("FAIL %s: got=%h expected=%h mask=%h", e.name, got, e.exp, e.mask);
        end
      end
    end
  endtask

  // Stall counter enters at 0 and leaves at 1.
  task automatic test_load_use();
    step_t t[$];
    step_t e;
    logic [15:0] got;
    t.push_back(ins("lu_ld6", 1, 2, 6, 0, 1, 1, 0, 16'h0, 16'h0));
    t.push_back(ins("lu_stall", 6, 12, 12, 0, 1, 0, 0, ev(1, 0, 0, 1, 0, 0, 0), M_A | M_B | M_ST | M_CNT));
    t.push_back(ins("lu_held", 6, 12, 12, 0, 1, 0, 0, ev(2, 0, 0, 0, 0, 0, 1), M_A | M_B | M_ST | M_CNT));
    for (int k = 0; k < 3; k++) t.push_back(bub("drain", 16'h0, 16'h0));
    t.push_back(ins("lu_ld6b", 1, 2, 6, 0, 1, 1, 0, 16'h0, 16'h0));
    t.push_back(ins("lu_imm_nostall", 1, 6, 13, 1, 1, 0, 0, ev(0, 1, 1, 0, 0, 0, 1), M_A | M_B | M_IMM | M_ST | M_CNT));
    for (int k = 0; k < 3; k++) t.push_back(bub("drain", 16'h0, 16'h0));
    foreach (t[i]) begin
      drive(t[i]);
      #2;
      e = sb.pop_front();
      got = obs();
      if (e.mask != 16'h0000) begin
        checks++;
        $display("step %s obs=%h", e.name, got);
        if ((got & e.mask) !== (e.exp & e.mask)) begin
          errors++;
          $display("FAIL %s: got=%h expected=%h mask=%h", e.name, got, e.exp, e.mask);
        end
      end
    end
  endtask

  task automatic test_flush();
    step_t t[$];
    step_t e;
    logic [15:0] got;
    t.push_back(ins("fl_ld6", 1, 2, 6, 0, 1, 1, 0, 16'h0, 16'h0));
    t.push_back(ins("fl_hazard", 6, 2, 13, 0, 1, 0, 1, ev(0, 0, 0, 0, 0, 0, 1), M_ST | M_CNT));
    t.push_back(ins("fl_bubble", 13, 2, 14, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 1), M_A | M_ST | M_CNT));
    for (int k = 0; k < 3; k++) t.push_back(bub("drain", 16'h0, 16'h0));
    foreach (t[i]) begin
      drive(t[i]);
      #2;
      e = sb.pop_front();
      got = obs();
      if (e.mask != 16'h0000) begin
        checks++;
        $display("step %s obs=%h", e.name, got);
        if ((got & e.mask) !== (e.exp & e.mask)) begin
          errors++;
          $display("FAIL %s: got=%h expected=%h mask=%h", e.name, got, e.exp, e.mask);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t t[$];
    step_t e;
    logic [15:0] got;
    t.push_back(ins("bb_ld4", 1, 2, 4, 0, 1, 1, 0, 16'h0, 16'h0));
    t.push_back(ins("bb_ld5", 4, 2, 5, 0, 1, 1, 0, ev(1, 0, 0, 1, 0, 0, 1), M_A | M_ST | M_CNT));
    t.push_back(ins("bb_ld5_held", 4, 2, 5, 0, 1, 1, 0, ev(2, 0, 0, 0, 0, 0, 2), M_A | M_ST | M_CNT));
    t.push_back(ins("bb_use", 5, 4, 15, 0, 1, 0, 0, ev(1, 3, 0, 1, 0, 0, 2), M_A | M_B | M_ST | M_CNT));
    t.push_back(ins("bb_use_held", 5, 4, 15, 0, 1, 0, 0, ev(2, 0, 0, 0, 0, 0, 3), M_A | M_B | M_ST | M_CNT));
    for (int k = 0; k < 3; k++) t.push_back(bub("drain", 16'h0, 16'h0));
    foreach (t[i]) begin
      drive(t[i]);
      #2;
      e = sb.pop_front();
      got = obs();
      if (e.mask != 16'h0000) begin
        checks++;
        $display("step %s obs=%h", e.name, got);
        if ((got & e.mask) !== (e.exp & e.mask)) begin
          errors++;
          $display("FAIL %s: got=%h expected=%h mask=%h", e.name, got, e.exp, e.mask);
        end
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    step_t t[$];
    step_t e;
    logic [15:0] got;
    t.push_back(ins("rm_ld6", 1, 2, 6, 0, 1, 1, 0, 16'h0, 16'h0));
    t.push_back(ins("rm_reset", 6, 6, 12, 0, 1, 0, 0, 16'h0000, M_A | M_B | M_IMM | M_ST));
    t[$].rst_n = 1'b0;
    t.push_back(ins("rm_after", 6, 6, 12, 0, 1, 0, 0, ev(0, 0, 0, 0, 0, 0, 0), M_A | M_B | M_ST | M_WE | M_CNT));
    for (int k = 0; k < 3; k++) t.push_back(bub("drain", 16'h0, 16'h0));
    foreach (t[i]) begin
      drive(t[i]);
      #2;
      e = sb.pop_front();
      got = obs();
      if (e.mask != 16'h0000) begin
        checks++;
        $display("step %s obs=%h", e.name, got);
        if ((got & e.mask) !== (e.exp & e.mask)) begin
          errors++;
          $display("FAIL %s: got=%h expected=%h mask=%h", e.name, got, e.exp, e.mask);
        end
      end
    end
  endtask

  // Sixteen load-use stalls from a cleared counter: fifteen fill it, the last must saturate.
  task automatic test_saturation();
    step_t t[$];
    step_t e;
    logic [15:0] got;
    for (int i = 0; i < 16; i++) begin
      t.push_back(ins("sat_ld6", 1, 2, 6, 0, 1, 1, 0, 16'h0, 16'h0));
      t.push_back(ins($sformatf("sat_stall%0d", i), 6, 2, 14, 0, 0, 0, 0,
                      ev(0, 0, 0, 1, 0, 0, i), M_ST | M_CNT));
      t.push_back(ins($sformatf("sat_held%0d", i), 6, 2, 14, 0, 0, 0, 0,
                      ev(0, 0, 0, 0, 0, 0, (i == 15) ? 15 : i + 1), M_ST | M_CNT));
    end
    foreach (t[i]) begin
      drive(t[i]);
      #2;
      e = sb.pop_front();
      got = obs();
      if (e.mask != 16'h0000) begin
        checks++;
        $display("step %s obs=%h", e.name, got);
        if ((got & e.mask) !== (e.exp & e.mask)) begin
          errors++;
          $display("FAIL %s: got=%h expected=%h mask=%h", e.name, got, e.exp, e.mask);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b1; id_RA = 5'd5; id_RB = 5'd5; id_RW = 5'd5;
    id_uses_imm = 1'b1; id_reg_write = 1'b1; id_is_load = 1'b1; flush = 1'b0;
    test_reset();
    test_alu_chain();
    test_priority();
    test_writeback();
    test_load_use();
    test_flush();
    test_back_to_back();
    test_reset_mid_stall();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/forwarding_hazard_ctrl.md
# forwarding_hazard_ctrl

- Sequences the operand-fetch datapath (register bank plus forwarding muxes) of the 5-stage 16-bit MIPS pipeline.
- Tracks destination registers of in-flight instructions in the EX, DM and WB stages.
- Drives `mux_sel_A`, `mux_sel_B` and `imm_sel` so the register bank block selects the newest value of each source operand.
- Raises `stall` on load-use hazards, drives the register-bank write port from the WB stage, and keeps a saturating stall counter.

## Interface
Parameters:
- `AW`, 5: register address width
- `CW`, 16: stall counter width

Ports:
- `clk` in 1: pipeline clock, rising edge
- `rst_n` in 1: synchronous, active-low reset
- `id_valid` in 1: decode-stage instruction present
- `id_RA`, `id_RB` in AW: source register addresses
- `id_RW` in AW: destination register address
- `id_uses_imm` in 1: B operand is the immediate
- `id_reg_write` in 1: instruction writes `id_RW`
- `id_is_load` in 1: instruction is a load
- `flush` in 1: kill the decode-stage instruction (taken branch)
- `mux_sel_A`, `mux_sel_B` out 2: forwarding selects (00 = reg bank, 01 = `ans_ex`, 10 = `ans_dm`, 11 = `ans_wb`)
- `imm_sel` out 1: B operand = `imm`
- `stall` out 1: hold PC and decode, insert a bubble
- `wb_RW` out AW: register-bank write address
- `wb_wr_en` out 1: register-bank write enable
- `stall_count` out CW: saturating count of stall cycles

## Operation
- Three stage records (EX, DM, WB), each holding {valid, RW, reg_write, is_load}. All registered.
- Each rising edge when `rst_n`=1:
  - WB <= DM; DM <= EX.
  - EX <= decode record if `id_valid` && !`stall` && !`flush`; otherwise EX <= bubble (valid=0).
- Hit in stage S for address X: S.valid && S.reg_write && S.RW==X && X!=0.
- Operand select for X (RA gives `mux_sel_A`, RB gives `mux_sel_B`), first match wins:
  - X==0: 00
  - EX hit: 01
  - DM hit: 10
  - WB hit: 11
  - no hit: 00
- `imm_sel` = `id_valid` && `id_uses_imm`. `mux_sel_B` is still computed when `imm_sel`=1, because stores need the forwarded RB data.
- `stall` = `id_valid` && !`flush` && EX.is_load && (EX hit on RA || (EX hit on RB && !`id_uses_imm`)).
- On the cycle after a stall, the load is in DM, so the same operand selects 10.
- `wb_RW` = WB.RW; `wb_wr_en` = WB.valid && WB.reg_write && WB.RW!=0.
- `stall_count` increments on every cycle with `stall`=1 and saturates at all-ones.
- `id_valid`=0: `mux_sel_A` = `mux_sel_B` = 00, `imm_sel`=0, `stall`=0.

## Timing
- `mux_sel_A`, `mux_sel_B`, `imm_sel` and `stall` are combinational from the decode inputs and the stage registers, with zero latency, and are valid in the same cycle as the instruction.
- `wb_RW` and `wb_wr_en` come straight from registers.
- The register bank writes on the edge that ends the WB cycle. A same-cycle read of that register resolves through select 11; the bank itself does not bypass.
- Reset: while `rst_n`=0, all combinational outputs are forced to 0. After the reset edge, all stages are bubbles, `wb_wr_en`=0, `wb_RW`=0, `stall_count`=0.
- Reset mid-stall drops `stall` immediately and discards in-flight instructions.
- `flush` together with a hazard: `flush` wins. `stall`=0, EX gets a bubble, and the counter does not increment.
- Back-to-back loads with a dependent pair stall exactly one cycle per dependency.

## Structure
- Shared package/include holds:
  - select constants `SEL_RF`=00, `SEL_EX`=01, `SEL_DM`=10, `SEL_WB`=11
  - the stage-record layout (valid, RW, reg_write, is_load)
- One sub-module, `operand_forward_select`. Inputs: an address plus the three stage records. Outputs: the 2-bit select and an `ex_load_hit` flag. Instantiated twice, for RA and RB.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `id_valid`=1 -> all outputs 0. After release, `stall_count`=0 and `wb_wr_en`=0 for 3 cycles.
- ALU chain: write r5, then next instruction reads RA=5 -> `mux_sel_A`=01. With one independent instruction between them -> 10. With two between -> 11. With three between -> 00.
- Priority: r7 written in both EX and DM, read RB=7 with `id_uses_imm`=0 -> `mux_sel_B`=01, `imm_sel`=0. RA=0 with r0 "written" in EX -> `mux_sel_A`=00.
- Load-use: load r6, then RA=6 -> `stall`=1 for one cycle and a bubble in EX. Next cycle `mux_sel_A`=10 and `stall_count`=1. Same case with RB=6 and `id_uses_imm`=1 -> no stall.
- Flush during hazard: load r6, then RA=6 with `flush`=1 -> `stall`=0, EX bubble, `stall_count` unchanged.
- Write-back and saturation: an instruction writing r9 issued in cycle n -> `wb_wr_en`=1 and `wb_RW`=9 in cycle n+3. Preload a counter near all-ones (CW=4, 15 stalls) plus one more stall -> `stall_count`=4'hF.
